// File: rtl/tx_fifo_packetizer.sv
// Drains whole packets of 32-bit words from the TX FIFO and emits framed bytes (sync, seq, payload).
// The optional trailer checksum is enabled by defining TX_PKT_CSUM_EN.
module tx_fifo_packetizer #(
  parameter int          PKT_WORDS  = 256,
  parameter int          WL_WIDTH   = 11,
  parameter int          IFG_CYCLES = 12,
  parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic                en,
  output logic                fifo_rd_en,
  input  logic [31:0]         fifo_rd_data,
  input  logic                fifo_rd_empty,
  input  logic [WL_WIDTH-1:0] fifo_rd_water_level,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                tx_sop,
  output logic                tx_eop,
  output logic                busy,
  output logic [15:0]         seq_num
);

  localparam int CW = $clog2(PKT_WORDS + 1);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [CW-1:0]       LAST_WORD = CW'(PKT_WORDS - 1);
  localparam logic [GW-1:0]       GAP_LAST  = GW'(IFG_CYCLES - 1);
  localparam logic [WL_WIDTH-1:0] WL_NEED   = WL_WIDTH'(PKT_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_LAT, S_PAY, S_END, S_GAP} state_t;

  state_t        r_state, w_nxt;
  logic [1:0]    r_byte;
  logic [CW-1:0] r_word_cnt;
  logic [31:0]   r_word;
  logic [15:0]   r_seq;
  logic [GW-1:0] r_gap;
  logic          w_hs;
  logic          w_last_word;
`ifdef TX_PKT_CSUM_EN
  logic [15:0]   r_csum;
`endif

  assign w_last_word = (r_word_cnt == LAST_WORD);
  assign w_hs        = tx_valid & tx_ready;
  assign busy        = (r_state != S_IDLE);
  assign seq_num     = r_seq;

  always_comb begin
    w_nxt      = r_state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_sop     = 1'b0;
    tx_eop     = 1'b0;
    fifo_rd_en = 1'b0;
    case (r_state)
      S_IDLE: if (en && !fifo_rd_empty && (fifo_rd_water_level >= WL_NEED)) w_nxt = S_HDR;
      S_HDR: begin
        tx_valid = 1'b1;
        tx_sop   = (r_byte == 2'd0);
        case (r_byte)
          2'd0:    tx_data = SYNC_WORD[15:8];
          2'd1:    tx_data = SYNC_WORD[7:0];
          2'd2:    tx_data = r_seq[15:8];
          default: tx_data = r_seq[7:0];
        endcase
        if (tx_ready && r_byte == 2'd3) w_nxt = S_RD;
      end
      // Empty here means the water level lied; wait rather than read garbage.
      S_RD: if (!fifo_rd_empty) begin
        fifo_rd_en = 1'b1;
        w_nxt      = S_LAT;
      end
      S_LAT: w_nxt = S_PAY;
      S_PAY: begin
        tx_valid = 1'b1;
        case (r_byte)
          2'd0:    tx_data = r_word[31:24];
          2'd1:    tx_data = r_word[23:16];
          2'd2:    tx_data = r_word[15:8];
          default: tx_data = r_word[7:0];
        endcase
`ifndef TX_PKT_CSUM_EN
        tx_eop = (r_byte == 2'd3) && w_last_word;
`endif
        if (tx_ready && r_byte == 2'd3) w_nxt = w_last_word ? S_END : S_RD;
      end
      S_END: begin
`ifdef TX_PKT_CSUM_EN
        tx_valid = 1'b1;
        tx_data  = r_byte[0] ? r_csum[7:0] : r_csum[15:8];
        tx_eop   = r_byte[0];
        if (tx_ready && r_byte[0]) w_nxt = S_GAP;
`else
        w_nxt = S_GAP;
`endif
      end
      S_GAP: if (r_gap == GAP_LAST) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) r_state <= S_IDLE;
    else           r_state <= w_nxt;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_byte     <= 2'd0;
      r_word_cnt <= '0;
      r_word     <= 32'h0;
      r_seq      <= 16'h0;
      r_gap      <= '0;
    end else begin
      if (r_state != w_nxt) r_byte <= 2'd0;
      else if (w_hs)        r_byte <= r_byte + 2'd1;
      if (r_state == S_IDLE)
        r_word_cnt <= '0;
      else if (r_state == S_PAY && w_hs && r_byte == 2'd3)
        r_word_cnt <= r_word_cnt + 1'b1;
      if (r_state == S_LAT) r_word <= fifo_rd_data;
      if (r_state == S_END && w_nxt == S_GAP) r_seq <= r_seq + 16'd1;
      if (r_state != S_GAP) r_gap <= '0;
      else                  r_gap <= r_gap + 1'b1;
    end
  end

`ifdef TX_PKT_CSUM_EN
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)
      r_csum <= 16'h0;
    else if (r_state == S_HDR && w_hs && r_byte == 2'd0)
      r_csum <= 16'h0;
    else if (r_state == S_PAY && w_hs)
      r_csum <= r_csum + {8'h00, tx_data};
  end
`endif

endmodule

// File: tb/tb_tx_fifo_packetizer.sv
// Directed bench for tx_fifo_packetizer with a small FIFO model and a handshake capture monitor.
module tb_tx_fifo_packetizer;
  localparam int PKT = 2;
  localparam int IFG = 2;
  localparam int WLW = 4;
`ifdef TX_PKT_CSUM_EN
  localparam int TRL = 2;
`else
  localparam int TRL = 0;
`endif
  localparam int PLEN = 4 + 4*PKT + TRL;

  logic           rd_clk = 1'b0;
  logic           rd_rst_n = 1'b0;
  logic           en = 1'b0;
  logic           fifo_rd_en;
  logic [31:0]    fifo_rd_data = 32'h0;
  logic           fifo_rd_empty;
  logic [WLW-1:0] fifo_rd_water_level;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic           tx_sop, tx_eop, busy;
  logic [15:0]    seq_num;

  int total = 0;
  int bad = 0;

  tx_fifo_packetizer #(.PKT_WORDS(PKT), .WL_WIDTH(WLW), .IFG_CYCLES(IFG), .SYNC_WORD(16'hA55A)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .en(en),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy), .seq_num(seq_num)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: read data appears the cycle after fifo_rd_en.
  logic [31:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_pulses = 0;
  assign fifo_rd_empty       = (wr_ptr == rd_ptr);
  assign fifo_rd_water_level = WLW'(wr_ptr - rd_ptr);
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
      rd_pulses    <= rd_pulses + 1;
    end
  end

  logic [7:0] cap_dat [0:511];
  logic       cap_sop [0:511];
  logic       cap_eop [0:511];
  int         cap_cyc [0:511];
  int cap_n = 0;
  int cyc = 0;
  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready && cap_n < 512) begin
      cap_dat[cap_n] <= tx_data;
      cap_sop[cap_n] <= tx_sop;
      cap_eop[cap_n] <= tx_eop;
      cap_cyc[cap_n] <= cyc;
      cap_n          <= cap_n + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_cap(input int target, output bit ok);
    int g = 0;
    while (cap_n < target && g < 1000) begin
      @(negedge rd_clk);
      g++;
    end
    ok = (cap_n >= target);
  endtask

  task automatic wait_idle(output bit ok);
    int g = 0;
    while (busy && g < 1000) begin
      @(negedge rd_clk);
      g++;
    end
    ok = !busy;
  endtask

  // Reference frame: header, payload MSB first, optional byte-sum trailer.
  function automatic logic [7:0] exp_byte(input logic [15:0] s, input logic [31:0] w0,
                                          input logic [31:0] w1, input int i);
    logic [31:0] w;
    logic [15:0] sum;
    int j;
    sum = 16'h0;
    for (int k = 0; k < 4; k++) sum = sum + 16'(w0[8*k +: 8]) + 16'(w1[8*k +: 8]);
    if (i == 0) return 8'hA5;
    if (i == 1) return 8'h5A;
    if (i == 2) return s[15:8];
    if (i == 3) return s[7:0];
    if (i < 4 + 4*PKT) begin
      w = ((i - 4) / 4 == 0) ? w0 : w1;
      j = (i - 4) % 4;
      return w[8*(3-j) +: 8];
    end
    if (i == 4 + 4*PKT) return sum[15:8];
    return sum[7:0];
  endfunction

  task automatic test_reset();
    @(negedge rd_clk);
    total++;
    if (fifo_rd_en !== 1'b0 || tx_valid !== 1'b0 || tx_sop !== 1'b0 || tx_eop !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: rd_en=%b valid=%b sop=%b eop=%b, want all 0", fifo_rd_en, tx_valid, tx_sop, tx_eop);
    end
    total++;
    if (busy !== 1'b0 || tx_data !== 8'h00 || seq_num !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: busy=%b data=%h seq=%h, want 0 00 0000", busy, tx_data, seq_num);
    end
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    en = 1'b1;
    tx_ready = 1'b1;
  endtask

  task automatic test_basic();
    int base, p0;
    bit ok;
    base = cap_n;
    p0 = rd_pulses;
    push(32'h01020304);
    push(32'h05060708);
    wait_cap(base + PLEN, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: got %0d bytes, want %0d", cap_n - base, PLEN); end
    for (int i = 0; i < PLEN; i++) begin
      total++;
      if (cap_dat[base+i] !== exp_byte(16'h0000, 32'h01020304, 32'h05060708, i) ||
          cap_sop[base+i] !== (i == 0) || cap_eop[base+i] !== (i == PLEN-1)) begin
        bad++;
        $display("FAIL basic_byte%0d: got %h sop=%b eop=%b, want %h sop=%b eop=%b", i, cap_dat[base+i],
                 cap_sop[base+i], cap_eop[base+i], exp_byte(16'h0000, 32'h01020304, 32'h05060708, i), i == 0, i == PLEN-1);
      end
    end
    wait_idle(ok);
    total++;
    if (rd_pulses - p0 !== PKT || cap_n !== base + PLEN) begin
      bad++;
      $display("FAIL basic_reads: got %0d reads %0d bytes, want %0d reads %0d bytes", rd_pulses - p0, cap_n - base, PKT, PLEN);
    end
    total++;
    if (seq_num !== 16'h0001) begin bad++; $display("FAIL basic_seq: got %h, want 0001", seq_num); end
  endtask

  task automatic test_threshold();
    int base, p0, viol;
    bit ok;
    base = cap_n;
    p0 = rd_pulses;
    viol = 0;
    push(32'h11223344);
    repeat (50) begin
      @(negedge rd_clk);
      if (fifo_rd_en || tx_valid || busy) viol++;
    end
    total++;
    if (viol !== 0 || rd_pulses !== p0) begin
      bad++;
      $display("FAIL thresh_hold: got %0d active cycles %0d reads, want 0 0", viol, rd_pulses - p0);
    end
    push(32'h55667788);
    @(negedge rd_clk);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || tx_sop !== 1'b1) begin
      bad++;
      $display("FAIL thresh_start: got valid=%b data=%h sop=%b, want 1 a5 1", tx_valid, tx_data, tx_sop);
    end
    wait_cap(base + PLEN, ok);
    for (int i = 0; i < PLEN; i++) begin
      total++;
      if (cap_dat[base+i] !== exp_byte(16'h0001, 32'h11223344, 32'h55667788, i)) begin
        bad++;
        $display("FAIL thresh_byte%0d: got %h, want %h", i, cap_dat[base+i], exp_byte(16'h0001, 32'h11223344, 32'h55667788, i));
      end
    end
    wait_idle(ok);
    total++;
    if (seq_num !== 16'h0002) begin bad++; $display("FAIL thresh_seq: got %h, want 0002", seq_num); end
  endtask

  task automatic test_backpressure();
    int base, p0, g;
    bit ok, hold;
    logic [7:0] pd;
    logic ps, pe;
    base = cap_n;
    p0 = rd_pulses;
    hold = 1'b0;
    pd = 8'h00; ps = 1'b0; pe = 1'b0;
    g = 0;
    push(32'hDEADBEEF);
    push(32'hCAFEF00D);
    while (cap_n < base + PLEN && g < 1000) begin
      @(negedge rd_clk);
      g++;
      if (hold) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== pd || tx_sop !== ps || tx_eop !== pe) begin
          bad++;
          $display("FAIL bp_stable: got valid=%b data=%h sop=%b eop=%b, want 1 %h %b %b", tx_valid, tx_data, tx_sop, tx_eop, pd, ps, pe);
        end
      end
      tx_ready = ~tx_ready;
      hold = tx_valid && !tx_ready;
      pd = tx_data; ps = tx_sop; pe = tx_eop;
    end
    tx_ready = 1'b1;
    total++;
    if (cap_n < base + PLEN) begin bad++; $display("FAIL bp_timeout: got %0d bytes, want %0d", cap_n - base, PLEN); end
    for (int i = 0; i < PLEN; i++) begin
      total++;
      if (cap_dat[base+i] !== exp_byte(16'h0002, 32'hDEADBEEF, 32'hCAFEF00D, i) || cap_eop[base+i] !== (i == PLEN-1)) begin
        bad++;
        $display("FAIL bp_byte%0d: got %h eop=%b, want %h eop=%b", i, cap_dat[base+i], cap_eop[base+i],
                 exp_byte(16'h0002, 32'hDEADBEEF, 32'hCAFEF00D, i), i == PLEN-1);
      end
    end
    wait_idle(ok);
    total++;
    if (rd_pulses - p0 !== PKT) begin bad++; $display("FAIL bp_reads: got %0d, want %0d", rd_pulses - p0, PKT); end
  endtask

  task automatic test_seq_wrap();
    int base, idle;
    bit ok;
    force dut.r_seq = 16'hFFFF;
    @(negedge rd_clk);
    release dut.r_seq;
    @(negedge rd_clk);
    base = cap_n;
    push(32'h0A0B0C0D);
    push(32'h10203040);
    push(32'h99887766);
    push(32'h00FF00FF);
    wait_cap(base + 2*PLEN, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_timeout: got %0d bytes, want %0d", cap_n - base, 2*PLEN); end
    for (int i = 0; i < PLEN; i++) begin
      total++;
      if (cap_dat[base+i] !== exp_byte(16'hFFFF, 32'h0A0B0C0D, 32'h10203040, i) ||
          cap_dat[base+PLEN+i] !== exp_byte(16'h0000, 32'h99887766, 32'h00FF00FF, i)) begin
        bad++;
        $display("FAIL wrap_byte%0d: got %h/%h, want %h/%h", i, cap_dat[base+i], cap_dat[base+PLEN+i],
                 exp_byte(16'hFFFF, 32'h0A0B0C0D, 32'h10203040, i), exp_byte(16'h0000, 32'h99887766, 32'h00FF00FF, i));
      end
    end
    idle = cap_cyc[base+PLEN] - cap_cyc[base+PLEN-1] - 1;
    total++;
    if (idle < IFG || cap_eop[base+PLEN-1] !== 1'b1 || cap_sop[base+PLEN] !== 1'b1) begin
      bad++;
      $display("FAIL wrap_ifg: got %0d idle cycles eop=%b sop=%b, want >=%0d 1 1", idle, cap_eop[base+PLEN-1], cap_sop[base+PLEN], IFG);
    end
    wait_idle(ok);
    total++;
    if (seq_num !== 16'h0001) begin bad++; $display("FAIL wrap_seq: got %h, want 0001", seq_num); end
  endtask

  task automatic test_reset_mid();
    int base, g, eops;
    bit ok;
    base = cap_n;
    push(32'h13579BDF);
    push(32'h2468ACE0);
    wait_cap(base + 8, ok);
    g = 0;
    while (!tx_valid && g < 100) begin
      @(negedge rd_clk);
      g++;
    end
    rd_rst_n = 1'b0;
    #1;
    total++;
    if (fifo_rd_en !== 1'b0 || tx_valid !== 1'b0 || tx_sop !== 1'b0 || tx_eop !== 1'b0 ||
        busy !== 1'b0 || tx_data !== 8'h00 || seq_num !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_out: got rd_en=%b valid=%b sop=%b eop=%b busy=%b data=%h seq=%h, want all 0",
               fifo_rd_en, tx_valid, tx_sop, tx_eop, busy, tx_data, seq_num);
    end
    repeat (2) @(negedge rd_clk);
    eops = 0;
    for (int i = base; i < cap_n; i++) if (cap_eop[i]) eops++;
    total++;
    if (eops !== 0 || cap_n !== base + 8) begin
      bad++;
      $display("FAIL rstmid_noeop: got %0d eops %0d bytes, want 0 eops 8 bytes", eops, cap_n - base);
    end
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    base = cap_n;
    push(32'h0F0E0D0C);
    push(32'h0B0A0908);
    wait_cap(base + PLEN, ok);
    for (int i = 0; i < PLEN; i++) begin
      total++;
      if (cap_dat[base+i] !== exp_byte(16'h0000, 32'h0F0E0D0C, 32'h0B0A0908, i)) begin
        bad++;
        $display("FAIL rstmid_byte%0d: got %h, want %h", i, cap_dat[base+i], exp_byte(16'h0000, 32'h0F0E0D0C, 32'h0B0A0908, i));
      end
    end
    wait_idle(ok);
    total++;
    if (seq_num !== 16'h0001) begin bad++; $display("FAIL rstmid_seq: got %h, want 0001", seq_num); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_backpressure();
    test_seq_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
